// File: rtl/submod_baz.sv
// Host-bus submodule: channel registers, status, RAM window and a handshaked
// bridge to a slow external peripheral. Optional ack timeout: SUBMOD_BAZ_TIMEOUT_EN.
module submod_baz #(
  parameter int AW        = 24,
  parameter int DW        = 32,
  parameter int NREG      = 4,
  parameter int RAM_BASE  = 'h100,
  parameter int RAM_DEPTH = 64,
  parameter int EXT_BASE  = 'h200,
  parameter int EXT_AW    = 2,
  parameter int EXT_DW    = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     bus_addr,
  input  logic [DW-1:0]     bus_wdata,
  input  logic              bus_we,
  input  logic              bus_re,
  output logic [DW-1:0]     bus_rdata,
  output logic              bus_rvalid,
  output logic              busy,
  output logic [EXT_AW-1:0] ext_addr,
  output logic [EXT_DW-1:0] ext_wdata,
  output logic              ext_we,
  output logic              ext_re,
  input  logic [EXT_DW-1:0] ext_rdata,
  input  logic              ext_ack
);

  localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int RAW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [AW-1:0] REG_END = AW'(NREG);
  localparam logic [AW-1:0] RAM_LO  = AW'(RAM_BASE);
  localparam logic [AW-1:0] RAM_HI  = AW'(RAM_BASE + RAM_DEPTH - 1);
  localparam logic [AW-1:0] EXT_LO  = AW'(EXT_BASE);
  localparam logic [AW-1:0] EXT_HI  = AW'(EXT_BASE + (2 ** EXT_AW) - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [DW-1:0] ext_zext(input logic [EXT_DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    r[EXT_DW-1:0] = d;
    return r;
  endfunction

  state_t state, state_nxt;
  logic [DW-1:0]  regs [NREG];
  logic [DW-1:0]  mem  [RAM_DEPTH];
  logic [7:0]     drop_cnt, tmo_cnt;
  logic           op_rd;
  logic [DW-1:0]  rdata_p1;
  logic           vld_p1;
  logic           resp_vld;
  logic [DW-1:0]  rd_mux;

  logic hit_reg, hit_stat, hit_ram, hit_ext;
  logic wr_go, rd_go, drop, ext_start, ack_ok, tmo_hit;
  logic [RIW-1:0] reg_idx;
  logic [RAW-1:0] ram_idx;

  assign hit_reg  = bus_addr < REG_END;
  assign hit_stat = bus_addr == REG_END;
  assign hit_ram  = (bus_addr >= RAM_LO) && (bus_addr <= RAM_HI);
  assign hit_ext  = (bus_addr >= EXT_LO) && (bus_addr <= EXT_HI);
  assign reg_idx  = bus_addr[RIW-1:0];
  assign ram_idx  = RAW'(bus_addr - RAM_LO);

  // A simultaneous write wins over the read; anything arriving while busy is dropped.
  assign wr_go     = bus_we & ~busy;
  assign rd_go     = bus_re & ~bus_we & ~busy;
  assign drop      = (bus_we | bus_re) & busy;
  assign ext_start = (wr_go | rd_go) & hit_ext;
  assign ack_ok    = (state == REQ) & ext_ack;

`ifdef SUBMOD_BAZ_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (state != REQ)   wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 8'd1;
  end

  assign tmo_hit = (state == REQ) & ~ext_ack & (wait_cnt == 8'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ext_start) state_nxt = REQ;
      REQ:     if (ack_ok || tmo_hit) state_nxt = op_rd ? RESP : IDLE;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    ext_we   = (state == REQ) & ~op_rd;
    ext_re   = (state == REQ) & op_rd;
    resp_vld = (state == RESP);
  end

  always_comb begin
    rd_mux = '0;
    if (hit_reg)       rd_mux = regs[reg_idx];
    else if (hit_stat) rd_mux[15:0] = {drop_cnt, tmo_cnt};
    else if (hit_ram)  rd_mux = mem[ram_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_go && hit_reg) begin
      regs[reg_idx] <= bus_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go && hit_ram) mem[ram_idx] <= bus_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (wr_go && hit_stat) begin
      drop_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (drop)    drop_cnt <= sat_inc(drop_cnt);
      if (tmo_hit) tmo_cnt  <= sat_inc(tmo_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_rd     <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else if (ext_start) begin
      op_rd     <= ~bus_we;
      ext_addr  <= bus_addr[EXT_AW-1:0];
      ext_wdata <= bus_wdata[EXT_DW-1:0];
    end
  end

  // Read return stage: local reads one cycle after bus_re, external reads in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_go & ~hit_ext;
      if (rd_go && !hit_ext)         rdata_p1 <= rd_mux;
      else if (ack_ok && op_rd)      rdata_p1 <= ext_zext(ext_rdata);
      else if (tmo_hit && op_rd)     rdata_p1 <= ext_zext('1);
    end
  end

  assign bus_rdata  = rdata_p1;
  assign bus_rvalid = vld_p1 | resp_vld;

endmodule

// File: tb/tb_submod_baz.sv
// Directed self-checking bench for submod_baz: registers, RAM, status, external
// bridge, busy drops, reset mid-transaction and (when enabled) ack timeout.
module tb_submod_baz;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we, bus_re;
  logic [31:0] bus_rdata;
  logic        bus_rvalid, busy;
  logic [1:0]  ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_we, ext_re;
  logic [7:0]  ext_rdata;
  logic        ext_ack;

  int checks = 0;
  int failures = 0;

  submod_baz dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .busy(busy),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_re(ext_re),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [23:0] a, input logic [31:0] exp);
    bus_addr = a; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    check({tag, "_vld"}, 32'(bus_rvalid), 32'd1);
    check(tag, bus_rdata, exp);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    ext_rdata = '0; ext_ack = 1'b0;
    #12;
    check("rst_outs", {bus_rdata[27:0], bus_rvalid, busy, ext_we, ext_re}, 32'd0);
    check("rst_ext", {22'd0, ext_addr, ext_wdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    read_chk("stat_rst", 24'd4, 32'd0);
    bus_write(24'd2, 32'h12345678);
    read_chk("reg2", 24'd2, 32'h12345678);
    tick();
    check("rvalid_one_cycle", 32'(bus_rvalid), 32'd0);

    bus_write(24'd0, 32'h0000DEAD);
    read_chk("raw_reg0", 24'd0, 32'h0000DEAD);

    // write and read together: write lands, no read return
    bus_addr = 24'd1; bus_wdata = 32'h55; bus_we = 1'b1; bus_re = 1'b1;
    tick();
    bus_we = 1'b0; bus_re = 1'b0;
    check("we_re_no_vld", 32'(bus_rvalid), 32'd0);
    read_chk("reg1", 24'd1, 32'h55);

    for (int i = 0; i < 64; i++) bus_write(24'h100 + 24'(i), 32'h80 + 32'(i));
    read_chk("ram_last", 24'h13F, 32'hBF);
    read_chk("ram_first", 24'h100, 32'h80);
    read_chk("unmapped", 24'h180, 32'd0);

    // external read with ack in the third request cycle, two drops meanwhile
    bus_addr = 24'h201; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    check("ext_re_c1", 32'(ext_re), 32'd1);
    check("ext_addr", 32'(ext_addr), 32'd1);
    check("busy_req", 32'(busy), 32'd1);
    bus_addr = 24'd0; bus_wdata = 32'hFFFF; bus_we = 1'b1;
    tick();
    bus_we = 1'b0;
    check("ext_re_c2", 32'(ext_re), 32'd1);
    bus_addr = 24'd1; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    check("ext_re_c3", 32'(ext_re), 32'd1);
    check("drop_rd_no_vld", 32'(bus_rvalid), 32'd0);
    ext_ack = 1'b1; ext_rdata = 8'hA5;
    tick();
    ext_ack = 1'b0; ext_rdata = 8'h00;
    check("ext_re_drop", 32'(ext_re), 32'd0);
    check("ext_rd_vld", 32'(bus_rvalid), 32'd1);
    check("ext_rd_data", bus_rdata, 32'h000000A5);
    check("busy_resp", 32'(busy), 32'd1);
    tick();
    check("resp_done", {30'd0, busy, bus_rvalid}, 32'd0);
    read_chk("reg0_kept", 24'd0, 32'h0000DEAD);
    read_chk("stat_drop2", 24'd4, 32'h00000200);
    bus_write(24'd4, 32'hFFFFFFFF);
    read_chk("stat_clr", 24'd4, 32'd0);

    // external write, acked in the first request cycle
    bus_write(24'h203, 32'h1234563C);
    check("ext_we", {ext_we, ext_re, ext_addr, ext_wdata}, {1'b1, 1'b0, 2'd3, 8'h3C});
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    check("ext_wr_done", {29'd0, ext_we, busy, bus_rvalid}, 32'd0);

    // stray ack in IDLE
    ext_ack = 1'b1;
    tick();
    ext_ack = 1'b0;
    check("idle_ack", {30'd0, busy, bus_rvalid}, 32'd0);

`ifdef SUBMOD_BAZ_TIMEOUT_EN
    bus_addr = 24'h200; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    n = 0;
    while (ext_re && n < 40) begin
      n++;
      tick();
    end
    check("tmo_cycles", 32'(n), 32'd15);
    check("tmo_vld", 32'(bus_rvalid), 32'd1);
    check("tmo_data", bus_rdata, 32'h000000FF);
    tick();
    ext_ack = 1'b1; ext_rdata = 8'h11;
    tick();
    ext_ack = 1'b0;
    check("late_ack", {30'd0, busy, bus_rvalid}, 32'd0);
    read_chk("stat_tmo", 24'd4, 32'h00000001);
`else
    n = 0;
    read_chk("stat_no_tmo", 24'd4, 32'd0);
`endif

    // reset while a read request is pending
    bus_addr = 24'h202; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    check("pre_rst_re", 32'(ext_re), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_re_low", {30'd0, ext_re, busy}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_rvalid) n++;
    end
    check("no_vld_after_rst", 32'(n), 32'd0);
    read_chk("reg2_rst", 24'd2, 32'd0);
    read_chk("reg0_rst", 24'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
